// File: rtl/region_enable_sequencer.sv
// Launches each enabled region in ascending index order and collects completion/timeout masks.
// Define REGION_SEQ_TIMEOUT_EN to add the per-region WAIT timeout and err_mask reporting.
module region_enable_sequencer #(
    parameter int unsigned NUM_REGIONS    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TMR_W          = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REGIONS-1:0] enable_mask,
    input  logic                   start,
    output logic [NUM_REGIONS-1:0] region_start,
    input  logic [NUM_REGIONS-1:0] region_done,
    output logic                   busy,
    output logic                   finish,
    output logic [NUM_REGIONS-1:0] done_mask,
    output logic [NUM_REGIONS-1:0] err_mask
);

    localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    // The timer must be able to reach TIMEOUT_CYCLES-1 without wrapping.
    if ((2 ** TMR_W) <= TIMEOUT_CYCLES) begin : g_tmr_w_check
        $error("region_enable_sequencer: TMR_W too small for TIMEOUT_CYCLES");
    end

    logic [2:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_REGIONS-1:0] mask_q, mask_d;
    logic [NUM_REGIONS-1:0] done_q, done_d;
    logic [NUM_REGIONS-1:0] region_start_q;
    logic                   busy_q;
    logic                   finish_q;
    logic                   advance;
    logic                   last_idx;
`ifdef REGION_SEQ_TIMEOUT_EN
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [NUM_REGIONS-1:0] err_q, err_d;
`endif

    assign last_idx = (idx_q == IDX_W'(NUM_REGIONS - 1));

    // Next-state and next-mask logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        done_d  = done_q;
        advance = 1'b0;
`ifdef REGION_SEQ_TIMEOUT_EN
        timer_d = timer_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = enable_mask;
                    done_d  = '0;
                    idx_d   = '0;
`ifdef REGION_SEQ_TIMEOUT_EN
                    err_d   = '0;
`endif
                    state_d = (enable_mask == '0) ? S_FIN : S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q[idx_q]) begin
                    state_d = S_LAUNCH;
                end else if (last_idx) begin
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_LAUNCH: begin
`ifdef REGION_SEQ_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef REGION_SEQ_TIMEOUT_EN
                timer_d = timer_q + TMR_W'(1);
`endif
                if (region_done[idx_q]) begin
                    done_d[idx_q] = 1'b1;
                    advance       = 1'b1;
                end
`ifdef REGION_SEQ_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d[idx_q] = 1'b1;
                    advance      = 1'b1;
                end
`endif
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (last_idx) begin
                state_d = S_FIN;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_SCAN;
            end
        end
    end

    // State and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            mask_q         <= '0;
            done_q         <= '0;
            region_start_q <= '0;
            busy_q         <= 1'b0;
            finish_q       <= 1'b0;
`ifdef REGION_SEQ_TIMEOUT_EN
            timer_q        <= '0;
            err_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            mask_q         <= mask_d;
            done_q         <= done_d;
            region_start_q <= (state_d == S_LAUNCH) ? (NUM_REGIONS'(1) << idx_d) : '0;
            busy_q         <= (state_d != S_IDLE);
            finish_q       <= (state_d == S_FIN);
`ifdef REGION_SEQ_TIMEOUT_EN
            timer_q        <= timer_d;
            err_q          <= err_d;
`endif
        end
    end

    assign region_start = region_start_q;
    assign busy         = busy_q;
    assign finish       = finish_q;
    assign done_mask    = done_q;
`ifdef REGION_SEQ_TIMEOUT_EN
    assign err_mask     = err_q;
`else
    assign err_mask     = '0;
`endif

endmodule

// File: tb/tb_region_enable_sequencer.sv
// Directed, table-driven bench for region_enable_sequencer with an in-bench region responder.
// Timeout rows run only when REGION_SEQ_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_region_enable_sequencer;

    localparam int unsigned NR  = 8;
    localparam int unsigned TO  = 16;
    localparam int unsigned TW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] enable_mask;
    logic          start;
    logic [NR-1:0] region_start;
    logic [NR-1:0] region_done;
    logic          busy;
    logic          finish;
    logic [NR-1:0] done_mask;
    logic [NR-1:0] err_mask;

    int checks = 0;
    int errors = 0;

    region_enable_sequencer #(
        .NUM_REGIONS   (NR),
        .TIMEOUT_CYCLES(TO),
        .TMR_W         (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_mask (enable_mask),
        .start       (start),
        .region_start(region_start),
        .region_done (region_done),
        .busy        (busy),
        .finish      (finish),
        .done_mask   (done_mask),
        .err_mask    (err_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        string     name;
        logic [7:0] mask;
        int        delay;      // done asserted in this WAIT cycle (1 = cycle after LAUNCH)
        logic [7:0] silent;    // regions that never answer
        logic [7:0] exp_done;
        logic [7:0] exp_err;
        int        exp_busy;   // busy cycles = 8 SCAN + sum(1 + wait) + 1 FIN
        int        exp_n;      // number of launches
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Run one full sequence, answering each launch after v.delay WAIT cycles.
    task automatic run_seq(input vec_t v);
        int busy_cnt = 0;
        int fin_cnt  = 0;
        int n        = 0;
        int cnt      = 0;
        logic [7:0] pbit = '0;
        logic [7:0] prev = '0;
        logic [7:0] seen = '0;
        logic       order_ok = 1'b1;
        logic       ended = 1'b0;
        enable_mask = v.mask;
        start = 1'b1;
        tick();
        start = 1'b0;
        enable_mask = ~v.mask;
        for (int c = 0; c < 400; c++) begin
            region_done = '0;
            if (busy) busy_cnt++;
            if (finish) fin_cnt++;
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) region_done = pbit;
            end
            if (region_start != '0) begin
                n++;
                if ($countones(region_start) != 1 || region_start <= prev) order_ok = 1'b0;
                prev = region_start;
                seen = seen | region_start;
                if ((region_start & v.silent) == '0) begin
                    pbit = region_start;
                    cnt  = v.delay;
                end
            end
            tick();
        end
        region_done = '0;
        chk({v.name, " ended"}, 32'(ended), 32'd1);
        chk({v.name, " done_mask"}, 32'(done_mask), 32'(v.exp_done));
        chk({v.name, " err_mask"}, 32'(err_mask), 32'(v.exp_err));
        chk({v.name, " busy_cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
        chk({v.name, " finish_pulses"}, 32'(fin_cnt), 32'd1);
        chk({v.name, " launched"}, 32'(seen), 32'(v.mask));
        chk({v.name, " launch_count"}, 32'(n), 32'(v.exp_n));
        chk({v.name, " launch_order"}, 32'(order_ok), 32'd1);
    endtask

    task automatic wait_launch(input string nm, input logic [7:0] exp, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (region_start == exp) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({nm, " launch_seen"}, 32'(ok), 32'd1);
    endtask

    initial begin
        logic ok;
        logic [7:0] stray;

        vecs.push_back('{"t1_mask05", 8'h05, 3, 8'h00, 8'h05, 8'h00, 17, 2});
        vecs.push_back('{"t2_mask00", 8'h00, 1, 8'h00, 8'h00, 8'h00, 1, 0});
        vecs.push_back('{"mask_ff_d1", 8'hFF, 1, 8'h00, 8'hFF, 8'h00, 25, 8});
        vecs.push_back('{"mask_80_d2", 8'h80, 2, 8'h00, 8'h80, 8'h00, 12, 1});
        vecs.push_back('{"mask_01_d1", 8'h01, 1, 8'h00, 8'h01, 8'h00, 11, 1});
        vecs.push_back('{"mask_a5_d2", 8'hA5, 2, 8'h00, 8'hA5, 8'h00, 21, 4});
        vecs.push_back('{"t5_done_last", 8'h01, 16, 8'h00, 8'h01, 8'h00, 26, 1});
`ifdef REGION_SEQ_TIMEOUT_EN
        vecs.push_back('{"t4_timeout", 8'h03, 2, 8'h01, 8'h02, 8'h01, 29, 2});
        vecs.push_back('{"t5_one_late", 8'h01, 17, 8'h00, 8'h00, 8'h01, 26, 1});
`endif

        reset = 1'b1;
        enable_mask = '0;
        start = 1'b0;
        region_done = '0;
        repeat (3) tick();
        chk("rst region_start", 32'(region_start), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst finish", 32'(finish), 32'd0);
        chk("rst done_mask", 32'(done_mask), 32'd0);
        chk("rst err_mask", 32'(err_mask), 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_seq(vecs[i]);
            tick();
        end

        // Stray done bit and restart attempt while region 7 is waiting
        enable_mask = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_launch("t3", 8'h80, ok);
        stray = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            region_done = 8'h08;
            enable_mask = 8'hFF;
            start = (c == 2);
            stray = stray | region_start;
        end
        tick();
        start = 1'b0;
        stray = stray | region_start;
        chk("t3 still_busy", 32'(busy), 32'd1);
        chk("t3 no_done_yet", 32'(done_mask), 32'd0);
        chk("t3 no_relaunch", 32'(stray), 32'd0);
        region_done = 8'h80;
        tick();
        region_done = '0;
        chk("t3 finish", 32'(finish), 32'd1);
        chk("t3 done_mask", 32'(done_mask), 32'h80);
        tick();
        chk("t3 idle", 32'(busy), 32'd0);
        chk("t3 restart_ignored", 32'(region_start), 32'd0);

        // Reset while region 2 is waiting
        enable_mask = 8'h07;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            wait_launch("t6_pre", 8'(1 << r), ok);
            tick();
            region_done = 8'(1 << r);
            tick();
            region_done = '0;
        end
        wait_launch("t6", 8'h04, ok);
        tick();
        tick();
        chk("t6 in_wait_busy", 32'(busy), 32'd1);
        chk("t6 partial_done", 32'(done_mask), 32'h03);
        reset = 1'b1;
        tick();
        chk("t6 rst region_start", 32'(region_start), 32'd0);
        chk("t6 rst busy", 32'(busy), 32'd0);
        chk("t6 rst finish", 32'(finish), 32'd0);
        chk("t6 rst done_mask", 32'(done_mask), 32'd0);
        chk("t6 rst err_mask", 32'(err_mask), 32'd0);
        reset = 1'b0;
        tick();
        run_seq('{"t6_rerun", 8'h04, 2, 8'h00, 8'h04, 8'h00, 12, 1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
